// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types for the unified rv_core memory arbiter.
// Request and response bundles share one 65-bit layout.
package rv_mem_pkg;

    localparam int MEM_REQ_W = 65;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } arb_state_e;

    typedef enum logic {
        GNT_IMEM,
        GNT_DMEM
    } grant_e;

    function automatic mem_req_t mk_req(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        mem_req_t r;
        r.we   = we;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Host port plus core IMEM/DMEM request/response channels.
// master = requesters (host and core), slave = arbiter.
interface rv_mem_arbiter_if;
    import rv_mem_pkg::*;

    logic        host_req_valid;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        host_busy;

    logic        imem_req_valid;
    logic        imem_req_ready;
    mem_req_t    imem_req;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    mem_req_t    imem_resp;

    logic        dmem_req_valid;
    logic        dmem_req_ready;
    mem_req_t    dmem_req;
    logic        dmem_resp_valid;
    logic        dmem_resp_ready;
    mem_req_t    dmem_resp;

    modport master (
        output host_req_valid, host_we, host_addr, host_wdata,
        input  host_rdata, host_rvalid, host_busy,
        output imem_req_valid, imem_req, imem_resp_ready,
        input  imem_req_ready, imem_resp_valid, imem_resp,
        output dmem_req_valid, dmem_req, dmem_resp_ready,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp
    );

    modport slave (
        input  host_req_valid, host_we, host_addr, host_wdata,
        output host_rdata, host_rvalid, host_busy,
        input  imem_req_valid, imem_req, imem_resp_ready,
        output imem_req_ready, imem_resp_valid, imem_resp,
        input  dmem_req_valid, dmem_req, dmem_resp_ready,
        output dmem_req_ready, dmem_resp_valid, dmem_resp
    );

endinterface

// File: rtl/rv_mem_arbiter_sram.sv
// Single-port synchronous word RAM, one-cycle read latency, write-first.
// Contents are never reset.
module rv_mem_sram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rv_mem_arbiter.sv
// Arbitrates host / IMEM / DMEM onto one RAM; host first, I/D round-robin.
// Define RV_MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic              clock,
    input  logic              reset,
    rv_mem_arbiter_if.slave   bus
`ifdef RV_MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_imem_grants,
    output logic [31:0]       stat_dmem_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    arb_state_e r_state;
    arb_state_e w_next;
    grant_e     r_last_grant;
    grant_e     r_gnt;
    logic       r_is_host;
    mem_req_t   r_req;
    logic       r_host_rvalid;

    logic       w_idle;
    logic       w_gnt_i;
    logic       w_gnt_d;
    logic       w_acc_host;
    logic       w_acc_i;
    logic       w_acc_d;
    logic       w_fire;
    logic       w_rsp_i;
    logic       w_rsp_d;
    mem_req_t   w_resp;
    logic [31:0] w_ram_rdata;

    // Tie-break: grant the channel that did not win last time.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (bus.imem_req_valid && bus.dmem_req_valid) begin
            w_gnt_i = (r_last_grant == GNT_DMEM);
            w_gnt_d = (r_last_grant == GNT_IMEM);
        end else begin
            w_gnt_i = bus.imem_req_valid;
            w_gnt_d = bus.dmem_req_valid;
        end
    end

    always_comb begin
        w_idle     = (r_state == IDLE) && !reset;
        w_acc_host = w_idle && bus.host_req_valid;
        bus.imem_req_ready = w_idle && !bus.host_req_valid && w_gnt_i;
        bus.dmem_req_ready = w_idle && !bus.host_req_valid && w_gnt_d;
        w_acc_i = bus.imem_req_ready && bus.imem_req_valid;
        w_acc_d = bus.dmem_req_ready && bus.dmem_req_valid;
    end

    always_comb begin
        w_rsp_i = (r_state == RESPOND) && (r_gnt == GNT_IMEM);
        w_rsp_d = (r_state == RESPOND) && (r_gnt == GNT_DMEM);
        w_fire  = (w_rsp_i && bus.imem_resp_ready)
               || (w_rsp_d && bus.dmem_resp_ready);
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_acc_host || w_acc_i || w_acc_d) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                w_next = r_is_host ? IDLE : RESPOND;
            end
            RESPOND: begin
                if (w_fire) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_grant  <= GNT_DMEM;
            r_gnt         <= GNT_IMEM;
            r_is_host     <= 1'b0;
            r_req         <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_host_rvalid <= (r_state == ACCESS) && r_is_host && !r_req.we;
            if (w_acc_host) begin
                r_is_host <= 1'b1;
                r_req     <= mk_req(bus.host_we, bus.host_addr,
                                    bus.host_wdata);
            end else if (w_acc_i) begin
                r_is_host    <= 1'b0;
                r_gnt        <= GNT_IMEM;
                r_last_grant <= GNT_IMEM;
                r_req        <= bus.imem_req;
            end else if (w_acc_d) begin
                r_is_host    <= 1'b0;
                r_gnt        <= GNT_DMEM;
                r_last_grant <= GNT_DMEM;
                r_req        <= bus.dmem_req;
            end
        end
    end

    // RAM is not gated by reset so a store already in ACCESS still commits.
    rv_mem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_sram (
        .i_clk   (clock),
        .i_en    (r_state == ACCESS),
        .i_we    (r_req.we),
        .i_addr  (r_req.addr[IDX_W-1:0]),
        .i_wdata (r_req.data),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_resp      = r_req;
        w_resp.data = r_req.we ? r_req.data : w_ram_rdata;
        bus.imem_resp_valid = w_rsp_i;
        bus.dmem_resp_valid = w_rsp_d;
        bus.imem_resp   = w_rsp_i ? w_resp : '0;
        bus.dmem_resp   = w_rsp_d ? w_resp : '0;
        bus.host_rvalid = r_host_rvalid;
        bus.host_rdata  = r_host_rvalid ? w_ram_rdata : 32'd0;
        bus.host_busy   = (r_state != IDLE);
    end

`ifdef RV_MEM_ARB_STATS_EN
    logic [31:0] r_stat_i;
    logic [31:0] r_stat_d;
    logic [31:0] r_stat_c;
    logic        w_conflict;

    always_comb begin
        w_conflict = w_idle
            && ((bus.imem_req_valid && bus.dmem_req_valid)
             || (bus.host_req_valid
              && (bus.imem_req_valid || bus.dmem_req_valid)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_i <= '0;
            r_stat_d <= '0;
            r_stat_c <= '0;
        end else begin
            if (w_acc_i && (r_stat_i != '1)) begin
                r_stat_i <= r_stat_i + 32'd1;
            end
            if (w_acc_d && (r_stat_d != '1)) begin
                r_stat_d <= r_stat_d + 32'd1;
            end
            if (w_conflict && (r_stat_c != '1)) begin
                r_stat_c <= r_stat_c + 32'd1;
            end
        end
    end

    assign stat_imem_grants = r_stat_i;
    assign stat_dmem_grants = r_stat_d;
    assign stat_conflicts   = r_stat_c;
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed plus randomized bench for rv_mem_arbiter.
// Reference model: a plain word array indexed by address modulo depth.
`timescale 1ns/1ps
module tb_rv_mem_arbiter;
    import rv_mem_pkg::*;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    rv_mem_arbiter_if bus();

`ifdef RV_MEM_ARB_STATS_EN
    logic [31:0] st_i;
    logic [31:0] st_d;
    logic [31:0] st_c;
`endif

    rv_mem_arbiter #(
        .DEPTH_WORDS (DEPTH),
        .INIT_FILE   ("")
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
`ifdef RV_MEM_ARB_STATS_EN
        ,
        .stat_imem_grants (st_i),
        .stat_dmem_grants (st_d),
        .stat_conflicts   (st_c)
`endif
    );

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit ch);
        return ch ? bus.dmem_req_ready : bus.imem_req_ready;
    endfunction

    function automatic logic rvld(input bit ch);
        return ch ? bus.dmem_resp_valid : bus.imem_resp_valid;
    endfunction

    function automatic mem_req_t rsp(input bit ch);
        return ch ? bus.dmem_resp : bus.imem_resp;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a % DEPTH);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.host_req_valid = 1'b0;
        bus.dmem_req_valid = 1'b0;
        bus.imem_req_valid = 1'b1;
        bus.imem_req = mk_req(1'b0, 32'd1, 32'd0);
        bus.imem_resp_ready = 1'b1;
        bus.dmem_resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", bus.host_busy, 0);
        chk("rst_rvalid", bus.host_rvalid, 0);
        chk("rst_rdata", bus.host_rdata, 0);
        chk("rst_iready", bus.imem_req_ready, 0);
        chk("rst_dready", bus.dmem_req_ready, 0);
        chk("rst_irvalid", bus.imem_resp_valid, 0);
        chk("rst_drvalid", bus.dmem_resp_valid, 0);
        chk("rst_iresp", bus.imem_resp, 0);
        chk("rst_dresp", bus.dmem_resp, 0);
`ifdef RV_MEM_ARB_STATS_EN
        chk("rst_stat_i", st_i, 0);
        chk("rst_stat_d", st_d, 0);
        chk("rst_stat_c", st_c, 0);
`endif
        bus.imem_req_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic host_op(input bit we, input logic [31:0] a,
                           input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (bus.host_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.host_req_valid = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.host_req_valid = 1'b0;
        chk("host_busy_t1", bus.host_busy, 1);
        chk("host_rvalid_t1", bus.host_rvalid, 0);
        @(negedge clk);
        chk("host_rvalid_t2", bus.host_rvalid, !we);
        chk("host_busy_t2", bus.host_busy, 0);
        if (we) mdl[idx(a)] = d;
        else chk("host_rdata", bus.host_rdata, mdl[idx(a)]);
    endtask

    task automatic core_op(input bit ch, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
        mem_req_t ex;
        int n = 0;
        ex = mk_req(we, a, we ? d : mdl[idx(a)]);
        if (we) mdl[idx(a)] = d;
        @(negedge clk);
        if (ch) begin
            bus.dmem_req_valid = 1'b1;
            bus.dmem_req = mk_req(we, a, d);
        end else begin
            bus.imem_req_valid = 1'b1;
            bus.imem_req = mk_req(we, a, d);
        end
        #1;
        while (!rdy(ch) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(ch ? "d_ready" : "i_ready", rdy(ch), 1);
        @(posedge clk);
        @(negedge clk);
        bus.imem_req_valid = 1'b0;
        bus.dmem_req_valid = 1'b0;
        chk("rsp_valid_t1", rvld(ch), 0);
        @(negedge clk);
        chk("rsp_valid_t2", rvld(ch), 1);
        chk(ch ? "d_resp" : "i_resp", rsp(ch), ex);
        @(negedge clk);
        chk("rsp_valid_after", rvld(ch), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_req_t ex;
        int got;
        int n;
        bus.host_req_valid  = 1'b0;
        bus.host_we         = 1'b0;
        bus.host_addr       = '0;
        bus.host_wdata      = '0;
        bus.imem_req_valid  = 1'b0;
        bus.imem_req        = '0;
        bus.imem_resp_ready = 1'b1;
        bus.dmem_req_valid  = 1'b0;
        bus.dmem_req        = '0;
        bus.dmem_resp_ready = 1'b1;

        do_reset();

        host_op(1'b1, 32'd5, 32'hDEAD_BEEF);
        host_op(1'b0, 32'd5, 32'd0);
        core_op(1'b1, 1'b1, 32'd9, 32'h0000_1234);
        core_op(1'b1, 1'b0, 32'd9, 32'd0);

        // IMEM response held under backpressure while DMEM waits.
        @(negedge clk);
        bus.imem_resp_ready = 1'b0;
        bus.imem_req_valid  = 1'b1;
        bus.imem_req        = mk_req(1'b0, 32'd5, 32'd0);
        bus.dmem_req_valid  = 1'b1;
        bus.dmem_req        = mk_req(1'b0, 32'd9, 32'd0);
        #1;
        chk("hold_i_ready", bus.imem_req_ready, 1);
        chk("hold_d_ready", bus.dmem_req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        bus.imem_req_valid = 1'b0;
        @(negedge clk);
        ex = mk_req(1'b0, 32'd5, mdl[5]);
        chk("hold_resp_t2", bus.imem_resp, ex);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_valid", bus.imem_resp_valid, 1);
            chk("hold_stable", bus.imem_resp, ex);
            chk("hold_d_blocked", bus.dmem_req_ready, 0);
        end
        bus.imem_resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("hold_released", bus.imem_resp_valid, 0);
        chk("hold_d_granted", bus.dmem_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.dmem_req_valid = 1'b0;
        @(negedge clk);
        chk("hold_d_resp", bus.dmem_resp, mk_req(1'b0, 32'd9, mdl[9]));
        @(negedge clk);

        // Contested I/D traffic from reset alternates starting with IMEM.
        do_reset();
        @(negedge clk);
        bus.imem_req_valid = 1'b1;
        bus.imem_req = mk_req(1'b0, 32'd5, 32'd0);
        bus.dmem_req_valid = 1'b1;
        bus.dmem_req = mk_req(1'b0, 32'd9, 32'd0);
        got = 0;
        n = 0;
        while (got < 20 && n < 200) begin
            #1;
            if (bus.imem_req_ready || bus.dmem_req_ready) begin
                chk("rr_i", bus.imem_req_ready, (got % 2) == 0);
                chk("rr_d", bus.dmem_req_ready, (got % 2) == 1);
                got++;
            end
            @(negedge clk);
            n++;
        end
        chk("rr_count", got, 20);
        bus.imem_req_valid = 1'b0;
        bus.dmem_req_valid = 1'b0;
        repeat (4) @(negedge clk);
`ifdef RV_MEM_ARB_STATS_EN
        chk("stat_imem", st_i, 10);
        chk("stat_dmem", st_d, 10);
        chk("stat_conf_ge10", st_c >= 10, 1);
`endif

        // Host and IMEM arrive together: host first.
        @(negedge clk);
        bus.host_req_valid = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 32'd5;
        bus.imem_req_valid = 1'b1;
        bus.imem_req = mk_req(1'b0, 32'd9, 32'd0);
        #1;
        chk("hv_i_blocked", bus.imem_req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        bus.host_req_valid = 1'b0;
        #1;
        chk("hv_busy", bus.host_busy, 1);
        chk("hv_i_wait", bus.imem_req_ready, 0);
        @(negedge clk);
        #1;
        chk("hv_rvalid", bus.host_rvalid, 1);
        chk("hv_rdata", bus.host_rdata, mdl[5]);
        chk("hv_busy_low", bus.host_busy, 0);
        chk("hv_i_ready", bus.imem_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.imem_req_valid = 1'b0;
        chk("hv_i_t1", bus.imem_resp_valid, 0);
        @(negedge clk);
        chk("hv_i_t2", bus.imem_resp_valid, 1);
        chk("hv_i_resp", bus.imem_resp, mk_req(1'b0, 32'd9, mdl[9]));
        @(negedge clk);

        // Reset during ACCESS of a store: no response, data kept.
        @(negedge clk);
        bus.dmem_req_valid = 1'b1;
        bus.dmem_req = mk_req(1'b1, 32'd3, 32'hCAFE_0003);
        #1;
        chk("rs_d_ready", bus.dmem_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.dmem_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rs_no_resp", bus.dmem_resp_valid, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rs_no_resp_later", bus.dmem_resp_valid, 0);
        end
        mdl[3] = 32'hCAFE_0003;
        host_op(1'b0, 32'd3, 32'd0);

        // Upper address bits are ignored.
        host_op(1'b1, 32'h0000_0407, 32'h7777_0007);
        core_op(1'b0, 1'b0, 32'd7, 32'd0);
        core_op(1'b1, 1'b0, 32'hABC0_0007, 32'd0);

        for (int i = 0; i < 32; i++) begin
            host_op(1'b1, 32'(i), $urandom());
        end
        for (int i = 0; i < 60; i++) begin
            int kind;
            bit we;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            we = 1'($urandom_range(0, 1));
            a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
            if (kind == 0) host_op(we, a, $urandom());
            else core_op(kind == 2, we, a, $urandom());
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
